// File: rtl/ex_mem_stage.sv
// ----------------------------------------------------------------------------
// ex_mem_stage
//   Execute stage plus EX/MEM pipeline register. Evaluates the ALU operation
//   selected by ALUCtrl_i, forms store addresses, and runs a 32-step
//   shift-add multiply while stalling the front of the pipe. The result, the
//   destination register and the Mem/WB control are registered toward the
//   memory stage.
//
// Ports
//   clk_i         clock, rising edge
//   rst_i         synchronous active-low reset
//   val1_i        operand A (rs1 data)
//   val2_i        operand B (imm or rs2, muxed upstream); store data
//   Simm_i        sign-extended store immediate
//   ALUCtrl_i     0010 add, 0110 sub, 0000 and, 0001 or, 1111 mul
//   rd_addr_i     destination register
//   Mem_i         [1]=MemRead, [0]=MemWrite
//   WB_i          register write enable
//   stall_o       upstream must hold ID/EX and the PC while high
//   alu_result_o  registered result or memory address
//   store_data_o  registered store data
//   rd_addr_o     registered destination
//   Mem_o         registered memory control
//   WB_o          registered write enable
// ----------------------------------------------------------------------------
module ex_mem_stage #(
    parameter int MUL_CYCLES = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] val1_i,
    input  logic [31:0] val2_i,
    input  logic [31:0] Simm_i,
    input  logic [3:0]  ALUCtrl_i,
    input  logic [4:0]  rd_addr_i,
    input  logic [1:0]  Mem_i,
    input  logic        WB_i,
    output logic        stall_o,
    output logic [31:0] alu_result_o,
    output logic [31:0] store_data_o,
    output logic [4:0]  rd_addr_o,
    output logic [1:0]  Mem_o,
    output logic        WB_o
);

    localparam int CW = $clog2(MUL_CYCLES);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_MUL = 4'b1111;

    localparam logic [CW-1:0] LAST_STEP = CW'(MUL_CYCLES - 1);

    logic [0:0]    state_q,  state_d;
    logic [CW-1:0] cnt_q,    cnt_d;
    logic [31:0]   mcand_q,  mcand_d;
    logic [31:0]   mplier_q, mplier_d;
    logic [31:0]   acc_q,    acc_d;
    logic [31:0]   result_q, result_d;
    logic [31:0]   sdata_q,  sdata_d;
    logic [4:0]    rd_q,     rd_d;
    logic [1:0]    mem_q,    mem_d;
    logic          wb_q,     wb_d;

    logic          mul_req;
    logic          stall;
    logic [31:0]   alu_res;
    logic [31:0]   acc_step;

    // Bubbles carry WB_i=0, so they can never start a multiply.
    assign mul_req = (ALUCtrl_i == ALU_MUL) && WB_i;

    // Accumulator value after the current shift-add step.
    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : 32'd0);

    always_comb begin
        alu_res = 32'd0;
        if (Mem_i[0]) begin
            alu_res = val1_i + Simm_i;
        end else begin
            case (ALUCtrl_i)
                ALU_ADD: alu_res = val1_i + val2_i;
                ALU_SUB: alu_res = val1_i - val2_i;
                ALU_AND: alu_res = val1_i & val2_i;
                ALU_OR:  alu_res = val1_i | val2_i;
                default: alu_res = 32'd0;
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        result_d = result_q;
        sdata_d  = sdata_q;
        rd_d     = rd_q;
        mem_d    = mem_q;
        wb_d     = wb_q;
        stall    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                sdata_d = val2_i;
                if (mul_req) begin
                    stall    = 1'b1;
                    mcand_d  = val1_i;
                    mplier_d = val2_i;
                    acc_d    = 32'd0;
                    cnt_d    = '0;
                    state_d  = ST_BUSY;
                    // Bubble toward MEM while the multiply runs.
                    result_d = 32'd0;
                    rd_d     = 5'd0;
                    mem_d    = 2'b00;
                    wb_d     = 1'b0;
                end else begin
                    result_d = alu_res;
                    rd_d     = rd_addr_i;
                    mem_d    = Mem_i;
                    wb_d     = WB_i;
                end
            end
            ST_BUSY: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST_STEP) begin
                    // Stall drops this cycle, so the inputs are the held
                    // multiply instruction: sample its rd/Mem/WB now.
                    state_d  = ST_IDLE;
                    cnt_d    = '0;
                    result_d = acc_step;
                    sdata_d  = val2_i;
                    rd_d     = rd_addr_i;
                    mem_d    = Mem_i;
                    wb_d     = WB_i;
                end else begin
                    stall = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            mcand_q  <= 32'd0;
            mplier_q <= 32'd0;
            acc_q    <= 32'd0;
            result_q <= 32'd0;
            sdata_q  <= 32'd0;
            rd_q     <= 5'd0;
            mem_q    <= 2'b00;
            wb_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            sdata_q  <= sdata_d;
            rd_q     <= rd_d;
            mem_q    <= mem_d;
            wb_q     <= wb_d;
        end
    end

    // Reset overrides any pending multiply request on the stall line.
    assign stall_o      = rst_i & stall;
    assign alu_result_o = result_q;
    assign store_data_o = sdata_q;
    assign rd_addr_o    = rd_q;
    assign Mem_o        = mem_q;
    assign WB_o         = wb_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// ----------------------------------------------------------------------------
// tb_ex_mem_stage
//   Scoreboard bench for ex_mem_stage. Each issued instruction pushes its
//   expected EX/MEM contents and arrival cycle; a negedge monitor pops and
//   compares whenever the DUT presents a non-bubble, and checks that bubbles
//   are all-zero otherwise.
// ----------------------------------------------------------------------------
module tb_ex_mem_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] val1_i, val2_i, Simm_i;
    logic [3:0]  ALUCtrl_i;
    logic [4:0]  rd_addr_i;
    logic [1:0]  Mem_i;
    logic        WB_i;
    logic        stall_o;
    logic [31:0] alu_result_o, store_data_o;
    logic [4:0]  rd_addr_o;
    logic [1:0]  Mem_o;
    logic        WB_o;

    ex_mem_stage #(.MUL_CYCLES(32)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .val1_i      (val1_i),
        .val2_i      (val2_i),
        .Simm_i      (Simm_i),
        .ALUCtrl_i   (ALUCtrl_i),
        .rd_addr_i   (rd_addr_i),
        .Mem_i       (Mem_i),
        .WB_i        (WB_i),
        .stall_o     (stall_o),
        .alu_result_o(alu_result_o),
        .store_data_o(store_data_o),
        .rd_addr_o   (rd_addr_o),
        .Mem_o       (Mem_o),
        .WB_o        (WB_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] res;
        logic [31:0] sdata;
        logic [4:0]  rd;
        logic [1:0]  mem;
        logic        wb;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk_i) cyc++;

    // Monitor: pop on every non-bubble output, otherwise require a clean bubble.
    always @(negedge clk_i) begin
        exp_t e;
        if (mon_en) begin
            if (WB_o === 1'b1 || Mem_o !== 2'b00) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("result",  alu_result_o, e.res);
                    chk("sdata",   store_data_o, e.sdata);
                    chk("rd",      {27'd0, rd_addr_o}, {27'd0, e.rd});
                    chk("mem",     {30'd0, Mem_o}, {30'd0, e.mem});
                    chk("wb",      {31'd0, WB_o}, {31'd0, e.wb});
                    chk("latency", cyc, e.cyc);
                    $display("txn rd=%0d res=0x%08h mem=%b wb=%b cyc=%0d",
                             rd_addr_o, alu_result_o, Mem_o, WB_o, cyc);
                end
            end else begin
                chk("bubble_res", alu_result_o, 32'd0);
                chk("bubble_rd",  {27'd0, rd_addr_o}, 32'd0);
            end
        end
    end

    function automatic logic [31:0] model(input logic [31:0] v1, input logic [31:0] v2,
                                          input logic [31:0] simm, input logic [3:0] ctl,
                                          input logic wb, input logic [1:0] mem);
        logic [31:0] r;
        r = 32'd0;
        if (mem[0])                      r = v1 + simm;
        else if (ctl == 4'b1111 && wb)   r = v1 * v2;
        else if (ctl == 4'b0010)         r = v1 + v2;
        else if (ctl == 4'b0110)         r = v1 - v2;
        else if (ctl == 4'b0000)         r = v1 & v2;
        else if (ctl == 4'b0001)         r = v1 | v2;
        return r;
    endfunction

    // Drive one instruction at a negedge, hold it while stall_o is high,
    // and check how many cycles the stall lasted.
    task automatic issue(input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] simm,
                         input logic [3:0] ctl, input logic [4:0] rd, input logic [1:0] mem,
                         input logic wb, input int exp_stall, input bit rel);
        exp_t e;
        int   n;
        @(negedge clk_i);
        if (rel) rst_i = 1'b1;
        val1_i = v1; val2_i = v2; Simm_i = simm; ALUCtrl_i = ctl;
        rd_addr_i = rd; Mem_i = mem; WB_i = wb;
        e.res = model(v1, v2, simm, ctl, wb, mem);
        e.sdata = v2; e.rd = rd; e.mem = mem; e.wb = wb;
        e.cyc = cyc + 1 + exp_stall;
        if (wb || mem != 2'b00) sb.push_back(e);
        #1;
        n = 0;
        while (stall_o === 1'b1 && n < 100) begin
            n++;
            @(negedge clk_i);
        end
        chk("stall_len", n, exp_stall);
    endtask

    initial begin
        // Reset with a multiply request on the inputs: no stall, outputs zero.
        rst_i = 1'b0;
        val1_i = 32'd5; val2_i = 32'd6; Simm_i = 32'd9; ALUCtrl_i = 4'b1111;
        rd_addr_i = 5'd3; Mem_i = 2'b10; WB_i = 1'b1;
        @(posedge clk_i);
        mon_en = 1'b1;
        @(posedge clk_i);
        #1;
        chk("rst_stall", {31'd0, stall_o}, 32'd0);
        chk("rst_wb",    {31'd0, WB_o}, 32'd0);
        chk("rst_mem",   {30'd0, Mem_o}, 32'd0);
        chk("rst_sdata", store_data_o, 32'd0);

        // Release reset together with an add; it must land one edge later.
        issue(32'd7, 32'd5, 32'd0, 4'b0010, 5'd1, 2'b00, 1'b1, 0, 1'b1);
        issue(32'd7, 32'd5, 32'd0, 4'b0110, 5'd2, 2'b00, 1'b1, 0, 1'b0);
        issue(32'd7, 32'd5, 32'd0, 4'b0000, 5'd3, 2'b00, 1'b1, 0, 1'b0);
        issue(32'd7, 32'd5, 32'd0, 4'b0001, 5'd4, 2'b00, 1'b1, 0, 1'b0);
        issue(32'd0, 32'd1, 32'd0, 4'b0110, 5'd5, 2'b00, 1'b1, 0, 1'b0);
        issue(32'd7, 32'd5, 32'd0, 4'b0101, 5'd6, 2'b00, 1'b1, 0, 1'b0);
        // Store: address from Simm, data from val2.
        issue(32'h100, 32'hDEAD, 32'hFFFF_FFFC, 4'b0010, 5'd0, 2'b01, 1'b0, 0, 1'b0);
        // Load uses the normal ALU path.
        issue(32'h200, 32'h10, 32'd0, 4'b0010, 5'd7, 2'b10, 1'b1, 0, 1'b0);

        // Multiplies, including all-ones and back-to-back.
        issue(32'd6, 32'd7, 32'd0, 4'b1111, 5'd8, 2'b00, 1'b1, 32, 1'b0);
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 4'b1111, 5'd9, 2'b00, 1'b1, 32, 1'b0);
        issue(32'd3, 32'd4, 32'd0, 4'b1111, 5'd10, 2'b00, 1'b1, 32, 1'b0);
        issue(32'd5, 32'd5, 32'd0, 4'b1111, 5'd11, 2'b00, 1'b1, 32, 1'b0);
        for (int i = 0; i < 3; i++) begin
            issue($urandom, $urandom, 32'd0, 4'b1111, 5'(12 + i), 2'b00, 1'b1, 32, 1'b0);
            issue($urandom, $urandom, 32'd0, 4'b0010, 5'(20 + i), 2'b00, 1'b1, 0, 1'b0);
        end

        // Abort a multiply with reset at step counter 10.
        @(negedge clk_i);
        val1_i = 32'd9; val2_i = 32'd9; ALUCtrl_i = 4'b1111;
        rd_addr_i = 5'd30; Mem_i = 2'b00; WB_i = 1'b1;
        @(posedge clk_i);
        repeat (10) @(posedge clk_i);
        @(negedge clk_i);
        chk("busy_stall", {31'd0, stall_o}, 32'd1);
        rst_i = 1'b0;
        #1;
        chk("rst_busy_stall", {31'd0, stall_o}, 32'd0);
        @(posedge clk_i);
        #1;
        chk("abort_res", alu_result_o, 32'd0);
        chk("abort_wb",  {31'd0, WB_o}, 32'd0);
        issue(32'd40, 32'd2, 32'd0, 4'b0010, 5'd31, 2'b00, 1'b1, 0, 1'b1);

        // Drain and confirm every expectation was consumed.
        @(negedge clk_i);
        val1_i = 32'd0; val2_i = 32'd0; ALUCtrl_i = 4'b0000;
        rd_addr_i = 5'd0; Mem_i = 2'b00; WB_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("sb_left", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Execute stage plus EX/MEM pipeline register: the consumer of the ID/EX register's outputs. It evaluates the ALU operation selected by the 4-bit ALU control code, forms load/store addresses, and performs a multi-cycle shift-add multiply while holding the front of the pipe with a stall. Results, destination register and the remaining Mem/WB control are registered toward the memory stage.

## Interface
Parameters
- MUL_CYCLES, 32, number of iterative multiply steps; fixed at the 32-bit operand width.

Ports
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, synchronous, active-low.
- val1_i  in  32  operand A (rs1 data).
- val2_i  in  32  operand B: immediate or rs2 data, already muxed upstream; store data for stores.
- Simm_i  in  32  sign-extended store immediate.
- ALUCtrl_i  in  4  0010 add, 0110 sub, 0000 and, 0001 or, 1111 mul; others undefined.
- rd_addr_i  in  5  destination register.
- Mem_i  in  2  [1]=MemRead, [0]=MemWrite.
- WB_i  in  1  register write enable.
- stall_o  out  1  high: upstream must hold ID/EX contents and the PC.
- alu_result_o  out  32  registered result or memory address.
- store_data_o  out  32  registered store data.
- rd_addr_o  out  5  registered destination.
- Mem_o  out  2  registered memory control.
- WB_o  out  1  registered write enable.

## Operation
- Reset (rst_i low at a rising edge): all registered outputs 0, FSM IDLE, step counter 0, accumulator 0. Any in-flight multiply is discarded. stall_o is 0 while rst_i is low.
- mul_req = (ALUCtrl_i == 4'b1111) && WB_i. Bubbles (WB_i=0, Mem_i=0) never start a multiply.
- Single-cycle result, combinational from inputs:
  - If Mem_i[0]=1 (store): result = val1_i + Simm_i.
  - Else: add gives val1+val2, sub gives val1-val2, and/or are bitwise, undefined codes give 0.
  - All arithmetic is modulo 2^32; no flags.
- store_data_o loads val2_i.
- FSM IDLE:
  - If no mul_req: the register loads the single-cycle result and rd/Mem/WB every edge.
  - On mul_req: stall_o=1 combinationally. At the edge, capture multiplicand=val1_i, multiplier=val2_i, clear accumulator, counter=0, go BUSY. The output register loads a bubble: WB_o=0, Mem_o=0, rd_addr_o=0, alu_result_o=0.
- FSM BUSY, each edge:
  - If multiplier bit0 is set, add the multiplicand to the accumulator.
  - Shift the multiplicand left 1 and the multiplier right 1 (32-bit, truncating).
  - Increment the counter.
  - stall_o=1 while counter < MUL_CYCLES-1. Outputs hold the bubble.
- BUSY with counter == MUL_CYCLES-1:
  - stall_o=0.
  - The edge performs the final step and loads alu_result_o = final low 32 bits of the product, with rd_addr_i/Mem_i/WB_i (held stable by the stall).
  - Go IDLE.
- Upstream inputs are only guaranteed stable while stall_o=1. The block samples them again only at the final BUSY edge.

## Timing
- Non-multiply ops: 1-cycle latency (input at edge N appears at outputs after edge N).
- Multiply presented before edge N: stall_o high for 32 cycles. Product visible after edge N+32. Next instruction accepted at edge N+32's following cycle.
- Back-to-back multiplies: the second is seen in IDLE the cycle after completion. It starts immediately, with no extra idle cycle.
- stall_o is purely combinational from state, counter and inputs; there is no stall output register.

## Test plan
- Reset: hold rst_i low 2 cycles with nonzero inputs -> all outputs 0, stall_o=0; release -> first add processed next edge.
- ALU ops: val1=7, val2=5 with 0010/0110/0000/0001 -> 12, 2, 5, 7. 0110 with 0-1 -> 0xFFFFFFFF. Undefined code 0101 -> 0.
- Store: Mem_i=01, val1=0x100, Simm=-4, val2=0xDEAD -> alu_result_o=0xFC, store_data_o=0xDEAD, Mem_o=01.
- Multiply: 6*7 -> stall_o high exactly 32 cycles, bubble outputs meanwhile, then alu_result_o=42 with rd/WB. 0xFFFFFFFF*0xFFFFFFFF -> 1.
- Back-to-back multiplies 3*4 then 5*5 -> results 12 and 25. Between the two products, outputs show the bubble for 32 cycles.
- Reset at BUSY counter 10 -> outputs 0, IDLE. A following add completes in 1 cycle with no stale product.
